// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: key-schedule FSM states, round constants and
// the word-rotation helper used by the key expansion.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PREP  = 2'd1,
        READY = 2'd2
    } ks_state_e;

    localparam int AES_NR = 10;

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon for the higher-numbered round of a step; zero outside 1..10.
    function automatic logic [7:0] rcon_of(input logic [3:0] idx);
        logic [7:0] r;
        r = 8'h00;
        if (idx >= 4'd1 && idx <= 4'd10) begin
            r = RCON[idx];
        end
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (one byte). Four instances form SubWord;
// also usable by a SubBytes stage.
module aes_sbox (
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_schedule.sv
// Sequential AES-128 round-key generator: walks K0..K10 forward, or pre-expands
// to K10 and walks back to K0 with the inverse recurrence.
module aes_key_schedule
    import aes_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_n,
    input  logic [127:0] key_i,
    input  logic         load_i,
    input  logic         dir_i,
    input  logic         next_i,
    output logic [127:0] roundkey_o,
    output logic [3:0]   round_o,
    output logic         valid_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam logic [3:0] LAST_ROUND = 4'(AES_NR);

    ks_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic         dir_q, dir_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;

    logic [31:0]  k0, k1, k2, k3;
    logic [31:0]  inv_w3;
    logic [31:0]  sub_in, sub_out, t_word;
    logic [3:0]   rcon_idx;
    logic         use_bwd;
    logic [127:0] fwd_key, bwd_key;

    assign k0 = key_q[127:96];
    assign k1 = key_q[95:64];
    assign k2 = key_q[63:32];
    assign k3 = key_q[31:0];

    // The single SubWord is shared: backward steps feed it the recovered w3.
    assign use_bwd  = (state_q == READY) && dir_q;
    assign inv_w3   = k3 ^ k2;
    assign sub_in   = rot_word(use_bwd ? inv_w3 : k3);
    assign rcon_idx = (state_q == READY && !dir_q) ? round_q + 4'd1 : round_q;
    assign t_word   = sub_out ^ {rcon_of(rcon_idx), 24'h000000};

    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
        aes_sbox u_sbox (
            .in_i  (sub_in[gi*8 +: 8]),
            .out_o (sub_out[gi*8 +: 8])
        );
    end

    always_comb begin
        logic [31:0] f4, f5, f6, f7;
        f4 = k0 ^ t_word;
        f5 = f4 ^ k1;
        f6 = f5 ^ k2;
        f7 = f6 ^ k3;
        fwd_key = {f4, f5, f6, f7};
        bwd_key = {k0 ^ t_word, k1 ^ k0, k2 ^ k1, inv_w3};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            round_q <= '0;
            dir_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        dir_d   = dir_q;
        if (load_i) begin
            key_d = key_i;
            dir_d = dir_i;
            if (dir_i) begin
                state_d = PREP;
                round_d = 4'd1;
            end else begin
                state_d = READY;
                round_d = 4'd0;
            end
        end else begin
            unique case (state_q)
                PREP: begin
                    // round_q counts pre-expansion steps and ends parked at 10.
                    key_d = fwd_key;
                    if (round_q == LAST_ROUND) begin
                        state_d = READY;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                READY: begin
                    if (next_i) begin
                        if (!dir_q && round_q != LAST_ROUND) begin
                            key_d   = fwd_key;
                            round_d = round_q + 4'd1;
                        end else if (dir_q && round_q != 4'd0) begin
                            key_d   = bwd_key;
                            round_d = round_q - 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        valid_d = (state_d == READY);
        busy_d  = (state_d == PREP);
        done_d  = (state_d == READY) &&
                  (dir_d ? (round_d == 4'd0) : (round_d == LAST_ROUND));
    end

    assign roundkey_o = key_q;
    assign round_o    = round_q;
    assign valid_o    = valid_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;

endmodule

// File: tb/tb_aes_key_schedule.sv
// Self-checking bench for aes_key_schedule against a FIPS-197 key-expansion
// model built from GF(2^8) arithmetic.
module tb_aes_key_schedule;

    logic         clk_i = 1'b0;
    logic         rst_n;
    logic [127:0] key_i;
    logic         load_i, dir_i, next_i;
    logic [127:0] roundkey_o;
    logic [3:0]   round_o;
    logic         valid_o, busy_o, done_o;
    logic [134:0] obs;

    int checks = 0;
    int errors = 0;
    logic [127:0] exp_k [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K2  = 128'hf2c295f27a96b9435935807a7359f67f;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] ZERO_K1  = 128'h62636363626363636263636362636363;

    aes_key_schedule dut (
        .clk_i      (clk_i),
        .rst_n      (rst_n),
        .key_i      (key_i),
        .load_i     (load_i),
        .dir_i      (dir_i),
        .next_i     (next_i),
        .roundkey_o (roundkey_o),
        .round_o    (round_o),
        .valid_o    (valid_o),
        .busy_o     (busy_o),
        .done_o     (done_o)
    );

    always #5 clk_i = ~clk_i;

    assign obs = {valid_o, busy_o, done_o, round_o, roundkey_o};

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    // S-box from first principles: multiplicative inverse (x^254) then affine map.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]), sbox_ref(t[7:0])};
                t = t ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) exp_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_load(input logic [127:0] key, input logic dir);
        key_i = key; dir_i = dir; load_i = 1'b1;
        tick();
        load_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load_i = 1'b0; next_i = 1'b0; dir_i = 1'b0; key_i = '0;
        tick(); tick();
        checks++;
        if (obs !== 135'd0) begin
            errors++; $display("FAIL reset_state: got %h expected 0", obs);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (obs !== 135'd0) begin
            errors++; $display("FAIL idle_after_reset: got %h expected 0", obs);
        end
        $display("test_reset: outputs %h", obs);
    endtask

    task automatic test_fips_forward;
        logic [134:0] exp_v;
        expand(FIPS_KEY);
        do_load(FIPS_KEY, 1'b0);
        exp_v = {3'b100, 4'd0, FIPS_KEY};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL fwd_load: got %h expected %h", obs, exp_v);
        end
        next_i = 1'b1;
        for (int r = 1; r <= 10; r++) begin
            tick();
            exp_v = {1'b1, 1'b0, (r == 10), 4'(r), exp_k[r]};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL fwd_step r=%0d: got %h expected %h", r, obs, exp_v);
            end
            if (r == 1) begin
                checks++;
                if (roundkey_o !== FIPS_K1) begin
                    errors++; $display("FAIL fips_k1: got %h expected %h", roundkey_o, FIPS_K1);
                end
            end
            if (r == 2) begin
                checks++;
                if (roundkey_o !== FIPS_K2) begin
                    errors++; $display("FAIL fips_k2: got %h expected %h", roundkey_o, FIPS_K2);
                end
            end
            $display("fwd step: round %0d key %h done %b", round_o, roundkey_o, done_o);
        end
        checks++;
        if ({done_o, roundkey_o} !== {1'b1, FIPS_K10}) begin
            errors++; $display("FAIL fips_k10: got done=%b %h expected done=1 %h", done_o, roundkey_o, FIPS_K10);
        end
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_v = {3'b101, 4'd10, FIPS_K10};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL fwd_hold: got %h expected %h", obs, exp_v);
            end
        end
        next_i = 1'b0;
    endtask

    task automatic test_fips_backward;
        logic [134:0] exp_v;
        int busy_cycles;
        expand(FIPS_KEY);
        do_load(FIPS_KEY, 1'b1);
        busy_cycles = 0;
        while (busy_o === 1'b1 && busy_cycles < 20) begin
            busy_cycles++;
            checks++;
            if (valid_o !== 1'b0) begin
                errors++; $display("FAIL prep_valid: got %b expected 0", valid_o);
            end
            tick();
        end
        checks++;
        if (busy_cycles != 10) begin
            errors++; $display("FAIL busy_len: got %0d expected 10", busy_cycles);
        end
        exp_v = {3'b100, 4'd10, FIPS_K10};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL bwd_ready: got %h expected %h", obs, exp_v);
        end
        $display("bwd prep: busy %0d cycles, round %0d key %h", busy_cycles, round_o, roundkey_o);
        for (int r = 9; r >= 0; r--) begin
            next_i = 1'b1;
            tick();
            next_i = 1'b0;
            exp_v = {1'b1, 1'b0, (r == 0), 4'(r), exp_k[r]};
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL bwd_step r=%0d: got %h expected %h", r, obs, exp_v);
            end
            $display("bwd step: round %0d key %h done %b", round_o, roundkey_o, done_o);
            tick();
        end
        checks++;
        if (roundkey_o !== FIPS_KEY) begin
            errors++; $display("FAIL bwd_k0: got %h expected %h", roundkey_o, FIPS_KEY);
        end
        next_i = 1'b1;
        tick();
        next_i = 1'b0;
        exp_v = {3'b101, 4'd0, FIPS_KEY};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL bwd_hold: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_reset_mid_prep;
        do_load(FIPS_KEY, 1'b1);
        tick(); tick(); tick();
        checks++;
        if ({valid_o, busy_o} !== 2'b01) begin
            errors++; $display("FAIL prep_busy: got v%b b%b expected v0 b1", valid_o, busy_o);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (obs !== 135'd0) begin
            errors++; $display("FAIL reset_mid_prep: got %h expected 0", obs);
        end
        next_i = 1'b1;
        tick();
        next_i = 1'b0;
        checks++;
        if (obs !== 135'd0) begin
            errors++; $display("FAIL next_after_reset: got %h expected 0", obs);
        end
        rst_n = 1'b0; key_i = FIPS_KEY; dir_i = 1'b0; load_i = 1'b1;
        tick();
        rst_n = 1'b1; load_i = 1'b0;
        checks++;
        if (obs !== 135'd0) begin
            errors++; $display("FAIL reset_over_load: got %h expected 0", obs);
        end
        $display("test_reset_mid_prep: outputs %h", obs);
    endtask

    task automatic test_load_priority;
        logic [127:0] key_b;
        logic [134:0] exp_v;
        key_b = {$urandom, $urandom, $urandom, $urandom};
        do_load(FIPS_KEY, 1'b0);
        next_i = 1'b1;
        tick(); tick(); tick();
        checks++;
        if (round_o !== 4'd3) begin
            errors++; $display("FAIL prio_round3: got %0d expected 3", round_o);
        end
        key_i = key_b; dir_i = 1'b0; load_i = 1'b1;
        tick();
        load_i = 1'b0; next_i = 1'b0;
        exp_v = {3'b100, 4'd0, key_b};
        checks++;
        if (obs !== exp_v) begin
            errors++; $display("FAIL load_over_next: got %h expected %h", obs, exp_v);
        end
        $display("test_load_priority: round %0d key %h", round_o, roundkey_o);
    endtask

    task automatic test_idle_pulses;
        logic [134:0] exp_v;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            next_i = 1'b1;
            tick();
            next_i = 1'b0;
            checks++;
            if (obs !== 135'd0) begin
                errors++; $display("FAIL idle_next: got %h expected 0", obs);
            end
        end
        expand(128'd0);
        do_load(128'd0, 1'b0);
        next_i = 1'b1;
        tick();
        next_i = 1'b0;
        exp_v = {3'b100, 4'd1, ZERO_K1};
        checks++;
        if (obs !== exp_v || exp_k[1] !== ZERO_K1) begin
            errors++; $display("FAIL zero_key_k1: got %h expected %h model %h", obs, exp_v, exp_k[1]);
        end
        $display("test_idle_pulses: round %0d key %h", round_o, roundkey_o);
    endtask

    task automatic test_random_walks;
        logic [127:0] key;
        logic         dir, nx;
        logic [134:0] exp_v;
        int r_exp, guard;
        for (int it = 0; it < 8; it++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            dir = 1'($urandom_range(0, 1));
            expand(key);
            do_load(key, dir);
            guard = 0;
            while (dir && busy_o === 1'b1 && guard < 20) begin
                guard++;
                tick();
            end
            if (guard >= 20) begin
                errors++; $display("FAIL rand_prep_timeout: busy still %b after %0d cycles", busy_o, guard);
            end
            r_exp = dir ? 10 : 0;
            for (int c = 0; c < 16; c++) begin
                exp_v = {1'b1, 1'b0, (dir ? r_exp == 0 : r_exp == 10), 4'(r_exp), exp_k[r_exp]};
                checks++;
                if (obs !== exp_v) begin
                    errors++; $display("FAIL rand_walk it=%0d c=%0d: got %h expected %h", it, c, obs, exp_v);
                end
                nx = 1'($urandom_range(0, 2) != 0);
                next_i = nx;
                tick();
                if (nx && !dir && r_exp < 10) r_exp++;
                if (nx && dir && r_exp > 0) r_exp--;
            end
            next_i = 1'b0;
            $display("random walk %0d: dir %b key %h ended round %0d", it, dir, key, round_o);
        end
    endtask

    initial begin
        test_reset();
        test_fips_forward();
        test_fips_backward();
        test_reset_mid_prep();
        test_load_priority();
        test_idle_pulses();
        test_random_walks();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
